// File: rtl/upsp_pkg.sv
// Shared types and constants for the raster writer: FSM state, pixel width
// and the position of each pixel inside a 2x2 block beat.
package upsp_pkg;

    localparam int PIXEL_WIDTH = 24;
    localparam int BEAT_WIDTH  = 4 * PIXEL_WIDTH;

    // Beat layout {d1,d2,d3,d4}, d1 at the MSBs.
    localparam int D1_LSB = 3 * PIXEL_WIDTH;
    localparam int D2_LSB = 2 * PIXEL_WIDTH;
    localparam int D3_LSB = 1 * PIXEL_WIDTH;
    localparam int D4_LSB = 0;

    typedef enum logic {
        TOP = 1'b0,
        BOT = 1'b1
    } upsp_state_e;

    // LSB of pixel idx (0 = d1 .. 3 = d4) inside a beat.
    function automatic int d_lsb(input int idx);
        return (3 - idx) * PIXEL_WIDTH;
    endfunction

    // Counter width that stays legal for a range of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsp_raster_writer_if.sv
// Block-beat input channel and single-pixel raster output channel.
// slave = the raster writer, master = the block source / pixel sink side.
interface upsp_raster_writer_if;
    import upsp_pkg::*;

    logic                   upsp_ac_wvalid;
    logic [BEAT_WIDTH-1:0]  upsp_ac_wdata;
    logic                   ac_upsp_wready;
    logic [PIXEL_WIDTH-1:0] wr_pdata;
    logic                   wr_pvalid;
    logic                   wr_pready;
    logic                   wr_plast;
    logic                   wr_psof;
    logic                   wr_peof;

    modport slave (
        input  upsp_ac_wvalid, upsp_ac_wdata, wr_pready,
        output ac_upsp_wready, wr_pdata, wr_pvalid, wr_plast, wr_psof, wr_peof
    );

    modport master (
        output upsp_ac_wvalid, upsp_ac_wdata, wr_pready,
        input  ac_upsp_wready, wr_pdata, wr_pvalid, wr_plast, wr_psof, wr_peof
    );

endinterface

// File: rtl/upsp_line_mem.sv
// One-line buffer holding the bottom pixel pair of every block of a row.
// Simple dual port, synchronous read with one cycle of latency, no reset.
module upsp_line_mem #(
    parameter int DEPTH  = 960,
    parameter int DATA_W = 48,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; holds its value while not enabled.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/upsp_raster_writer.sv
// Converts 2x2 upscaled block beats into a raster pixel stream.
// Top-row pixels stream straight out; bottom-row pairs are parked in a line
// buffer and drained after the output line completes.
// Optional UPSP_RW_PERF_EN adds stall_cnt / frame_cnt performance counters.
module upsp_raster_writer
    import upsp_pkg::*;
#(
    parameter int IN_WIDTH  = 960,
    parameter int IN_HEIGHT = 540
) (
    input  logic                clk,
    input  logic                rst_n,
    upsp_raster_writer_if.slave bus
`ifdef UPSP_RW_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [15:0]         frame_cnt
`endif
);

    localparam int COL_W = cnt_width(IN_WIDTH);
    localparam int ROW_W = cnt_width(IN_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

    upsp_state_e            r_state;
    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    logic                   r_pend_v;
    logic [PIXEL_WIDTH-1:0] r_pend_data;
    logic                   r_pend_last;
    logic                   r_row_done;
    logic                   r_half;
    logic                   r_bot_done;
    logic [PIXEL_WIDTH-1:0] r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_out_sof;
    logic                   r_out_eof;

    logic [PIXEL_WIDTH-1:0]   w_d [4];
    logic [2*PIXEL_WIDTH-1:0] w_rd_data;
    logic [PIXEL_WIDTH-1:0]   w_rd_d3;
    logic [PIXEL_WIDTH-1:0]   w_rd_d4;
    logic                     w_wready;
    logic                     w_out_free;
    logic                     w_out_hs;
    logic                     w_accept;
    logic                     w_top_exit;
    logic                     w_bot_load;
    logic                     w_rd_en;
    logic [COL_W-1:0]         w_rd_addr;

    // Split the beat into its four pixels.
    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_d[gi] = bus.upsp_ac_wdata[d_lsb(gi) +: PIXEL_WIDTH];
    end

    assign w_rd_d3 = w_rd_data[PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_rd_d4 = w_rd_data[0 +: PIXEL_WIDTH];

    // The output register can take a new pixel when empty or being drained.
    assign w_out_free = ~r_out_valid | bus.wr_pready;
    assign w_out_hs   = r_out_valid & bus.wr_pready;

    // A finished row blocks new beats until its last d2 leaves, so the next
    // row's first block cannot slip in ahead of the bottom line.
    assign w_wready   = (r_state == TOP) & ~r_pend_v & ~r_row_done & w_out_free;
    assign w_accept   = bus.upsp_ac_wvalid & w_wready;
    assign w_top_exit = (r_state == TOP) & r_row_done & ~r_pend_v & w_out_hs;
    assign w_bot_load = (r_state == BOT) & w_out_free & ~r_bot_done;

    // Entry 0 is fetched on the way into BOT; later entries are prefetched
    // while the previous entry's d4 is being loaded.
    assign w_rd_en   = w_top_exit | (w_bot_load & r_half & (r_col != COL_LAST));
    assign w_rd_addr = w_top_exit ? '0 : r_col + COL_W'(1);

    upsp_line_mem #(
        .DEPTH  (IN_WIDTH),
        .DATA_W (2 * PIXEL_WIDTH),
        .ADDR_W (COL_W)
    ) u_line_mem (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_col),
        .i_wr_data ({w_d[2], w_d[3]}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Main FSM: block intake in TOP, line-buffer drain in BOT, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= TOP;
            r_col       <= '0;
            r_row       <= '0;
            r_pend_v    <= 1'b0;
            r_pend_data <= '0;
            r_pend_last <= 1'b0;
            r_row_done  <= 1'b0;
            r_half      <= 1'b0;
            r_bot_done  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else begin
            case (r_state)
                TOP: begin
                    if (w_accept) begin
                        r_out_data  <= w_d[0];
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_out_sof   <= (r_col == '0) && (r_row == '0);
                        r_out_eof   <= 1'b0;
                        r_pend_data <= w_d[1];
                        r_pend_v    <= 1'b1;
                        r_pend_last <= (r_col == COL_LAST);
                        if (r_col == COL_LAST) begin
                            r_row_done <= 1'b1;
                            r_col      <= '0;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end else if (r_pend_v && w_out_free) begin
                        r_out_data  <= r_pend_data;
                        r_out_valid <= 1'b1;
                        r_out_last  <= r_pend_last;
                        r_out_sof   <= 1'b0;
                        r_out_eof   <= 1'b0;
                        r_pend_v    <= 1'b0;
                    end else if (w_top_exit) begin
                        r_state     <= BOT;
                        r_row_done  <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_half      <= 1'b0;
                        r_bot_done  <= 1'b0;
                    end else if (w_out_free) begin
                        r_out_valid <= 1'b0;
                    end
                end
                BOT: begin
                    if (r_bot_done) begin
                        if (w_out_hs) begin
                            r_state     <= TOP;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_eof   <= 1'b0;
                            r_bot_done  <= 1'b0;
                            r_col       <= '0;
                            r_row       <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
                        end
                    end else if (w_out_free) begin
                        r_out_valid <= 1'b1;
                        r_out_sof   <= 1'b0;
                        if (!r_half) begin
                            r_out_data <= w_rd_d3;
                            r_out_last <= 1'b0;
                            r_out_eof  <= 1'b0;
                            r_half     <= 1'b1;
                        end else begin
                            r_out_data <= w_rd_d4;
                            r_out_last <= (r_col == COL_LAST);
                            r_out_eof  <= (r_col == COL_LAST) && (r_row == ROW_LAST);
                            r_half     <= 1'b0;
                            if (r_col == COL_LAST) begin
                                r_bot_done <= 1'b1;
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.ac_upsp_wready = w_wready;
    assign bus.wr_pdata       = r_out_data;
    assign bus.wr_pvalid      = r_out_valid;
    assign bus.wr_plast       = r_out_last;
    assign bus.wr_psof        = r_out_sof;
    assign bus.wr_peof        = r_out_eof;

`ifdef UPSP_RW_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_frame_cnt;

    // Saturating stall counter and wrapping completed-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (r_out_valid && !bus.wr_pready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_out_hs && r_out_eof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign frame_cnt = r_frame_cnt;
`endif

endmodule
